butterfly2_tw: RTL and testbench

BUTTERFLY2_TW -- requirements
Module: butterfly2_tw

---
 rtl/butterfly2_tw.sv | 158 +++++++++++++++
 tb/tb_butterfly2_tw.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/butterfly2_tw.sv
// Radix-2 decimation-in-frequency butterfly: x = a + b, y = (a - b) * w.
// Three ce-gated pipeline stages with per-sample rounding/scaling, saturation and a sticky overflow flag.
module butterfly2_tw #(
  parameter int width    = 16,
  parameter int tw_width = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ce,
  input  logic                       valid_i,
  input  logic                       scale_i,
  input  logic signed [width-1:0]    ar,
  input  logic signed [width-1:0]    ai,
  input  logic signed [width-1:0]    br,
  input  logic signed [width-1:0]    bi,
  input  logic signed [tw_width-1:0] wr,
  input  logic signed [tw_width-1:0] wi,
  input  logic                       ovf_clr,
  output logic                       valid_o,
  output logic signed [width-1:0]    xr,
  output logic signed [width-1:0]    xi,
  output logic signed [width-1:0]    yr,
  output logic signed [width-1:0]    yi,
  output logic                       ovf_o
);

  localparam int PW = width + tw_width + 2;
  localparam int XW = width + 2;

  localparam logic signed [PW-1:0] Y_MAX   = {{(PW-width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [PW-1:0] Y_MIN   = {{(PW-width+1){1'b1}}, {(width-1){1'b0}}};
  localparam logic signed [XW-1:0] X_MAX   = {{(XW-width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [XW-1:0] X_MIN   = {{(XW-width+1){1'b1}}, {(width-1){1'b0}}};
  localparam logic signed [PW-1:0] Y_BIAS0 = {{(PW-tw_width+1){1'b0}}, 1'b1, {(tw_width-2){1'b0}}};
  localparam logic signed [PW-1:0] Y_BIAS1 = {{(PW-tw_width){1'b0}}, 1'b1, {(tw_width-1){1'b0}}};
  localparam logic signed [XW-1:0] X_ONE   = {{(XW-1){1'b0}}, 1'b1};

  // Returned as {clamped, value}
  function automatic logic [width:0] sat_y(input logic signed [PW-1:0] v);
    if (v > Y_MAX)      sat_y = {1'b1, Y_MAX[width-1:0]};
    else if (v < Y_MIN) sat_y = {1'b1, Y_MIN[width-1:0]};
    else                sat_y = {1'b0, v[width-1:0]};
  endfunction

  function automatic logic [width:0] sat_x(input logic signed [XW-1:0] v);
    if (v > X_MAX)      sat_x = {1'b1, X_MAX[width-1:0]};
    else if (v < X_MIN) sat_x = {1'b1, X_MIN[width-1:0]};
    else                sat_x = {1'b0, v[width-1:0]};
  endfunction

  // Stage 1 registers; the twiddle travels with its sample into the product stage
  logic                       v1, sc1;
  logic signed [width:0]      d_r1, d_i1, s_r1, s_i1;
  logic signed [tw_width-1:0] w_r1, w_i1;

  // Stage 2 registers
  logic                       v2, sc2;
  logic signed [PW-1:0]       p_r2, p_i2;
  logic signed [width:0]      s_r2, s_i2;

  // Stage 2 combinational
  logic signed [PW-1:0] dr_e, di_e, wr_e, wi_e, p_r_n, p_i_n;

  // Stage 3 combinational
  logic signed [PW-1:0] yb_r, yb_i, ys_r, ys_i;
  logic signed [XW-1:0] xe_r, xe_i, xs_r, xs_i;
  logic [width:0]       q_xr, q_xi, q_yr, q_yi;
  logic                 clamp_any;

  always_comb begin
    dr_e  = {{(PW-width-1){d_r1[width]}}, d_r1};
    di_e  = {{(PW-width-1){d_i1[width]}}, d_i1};
    wr_e  = {{(PW-tw_width){w_r1[tw_width-1]}}, w_r1};
    wi_e  = {{(PW-tw_width){w_i1[tw_width-1]}}, w_i1};
    p_r_n = dr_e * wr_e - di_e * wi_e;
    p_i_n = dr_e * wi_e + di_e * wr_e;
  end

  always_comb begin
    yb_r = p_r2 + (sc2 ? Y_BIAS1 : Y_BIAS0);
    yb_i = p_i2 + (sc2 ? Y_BIAS1 : Y_BIAS0);
    ys_r = sc2 ? (yb_r >>> tw_width) : (yb_r >>> (tw_width-1));
    ys_i = sc2 ? (yb_i >>> tw_width) : (yb_i >>> (tw_width-1));
    xe_r = {s_r2[width], s_r2};
    xe_i = {s_i2[width], s_i2};
    xs_r = sc2 ? ((xe_r + X_ONE) >>> 1) : xe_r;
    xs_i = sc2 ? ((xe_i + X_ONE) >>> 1) : xe_i;
    q_xr = sat_x(xs_r);
    q_xi = sat_x(xs_i);
    q_yr = sat_y(ys_r);
    q_yi = sat_y(ys_i);
    clamp_any = q_xr[width] | q_xi[width] | q_yr[width] | q_yi[width];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v1   <= 1'b0;
      sc1  <= 1'b0;
      d_r1 <= '0;
      d_i1 <= '0;
      s_r1 <= '0;
      s_i1 <= '0;
      w_r1 <= '0;
      w_i1 <= '0;
    end else if (ce) begin
      v1   <= valid_i;
      sc1  <= scale_i;
      d_r1 <= {ar[width-1], ar} - {br[width-1], br};
      d_i1 <= {ai[width-1], ai} - {bi[width-1], bi};
      s_r1 <= {ar[width-1], ar} + {br[width-1], br};
      s_i1 <= {ai[width-1], ai} + {bi[width-1], bi};
      w_r1 <= wr;
      w_i1 <= wi;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v2   <= 1'b0;
      sc2  <= 1'b0;
      p_r2 <= '0;
      p_i2 <= '0;
      s_r2 <= '0;
      s_i2 <= '0;
    end else if (ce) begin
      v2   <= v1;
      sc2  <= sc1;
      p_r2 <= p_r_n;
      p_i2 <= p_i_n;
      s_r2 <= s_r1;
      s_i2 <= s_i1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_o <= 1'b0;
      xr      <= '0;
      xi      <= '0;
      yr      <= '0;
      yi      <= '0;
    end else if (ce) begin
      valid_o <= v2;
      xr      <= q_xr[width-1:0];
      xi      <= q_xi[width-1:0];
      yr      <= q_yr[width-1:0];
      yi      <= q_yi[width-1:0];
    end
  end

  // Clear is honoured even while the pipe is stalled; a same-cycle set overrides it
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          ovf_o <= 1'b0;
    else if (ce && v2 && clamp_any)    ovf_o <= 1'b1;
    else if (ovf_clr)                  ovf_o <= 1'b0;
  end

endmodule

// File: tb/tb_butterfly2_tw.sv
// Directed-vector bench for butterfly2_tw (width=16, tw_width=16).
module tb_butterfly2_tw;

  logic               CLK = 1'b0;
  logic               RST;
  logic               ce, valid_i, scale_i, ovf_clr;
  logic signed [15:0] ar, ai, br, bi, wr, wi;
  logic               valid_o, ovf_o;
  logic signed [15:0] xr, xi, yr, yi;

  int n_vec = 0;
  int n_err = 0;
  logic [65:0] got, expv;

  butterfly2_tw #(.width(16), .tw_width(16)) dut (
    .CLK(CLK), .RST(RST), .ce(ce), .valid_i(valid_i), .scale_i(scale_i),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi), .ovf_clr(ovf_clr),
    .valid_o(valid_o), .xr(xr), .xi(xi), .yr(yr), .yi(yi), .ovf_o(ovf_o)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int a_r, input int a_i, input int b_r, input int b_i,
                       input int w_r, input int w_i, input logic sc, input logic v);
    ar = 16'(a_r); ai = 16'(a_i); br = 16'(b_r); bi = 16'(b_i);
    wr = 16'(w_r); wi = 16'(w_i); scale_i = sc; valid_i = v;
  endtask

  // Packs {valid, ovf, xr, xi, yr, yi} for a one-line comparison
  function automatic logic [65:0] pack(input logic v, input logic o, input int x_r,
                                       input int x_i, input int y_r, input int y_i);
    return {v, o, 16'(x_r), 16'(x_i), 16'(y_r), 16'(y_i)};
  endfunction

  task automatic test_reset();
    RST = 1'b0; ce = 1'b1; ovf_clr = 1'b0;
    drive(1000, 200, 600, -100, 16384, 0, 1'b0, 1'b1);
    tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL reset_state got=%h exp=%h", got, expv); end
    valid_i = 1'b0;
    RST = 1'b1;
  endtask

  task automatic test_basic();
    drive(1000, 200, 600, -100, 16384, 0, 1'b0, 1'b1);
    tick(); valid_i = 1'b0; tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 0, 1600, 100, 200, 150);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL basic got=%h exp=%h", got, expv); end
  endtask

  task automatic test_scale();
    drive(1000, 200, 600, -100, 16384, 0, 1'b1, 1'b1);
    tick(); valid_i = 1'b0; tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 0, 800, 50, 100, 75);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL scale got=%h exp=%h", got, expv); end
  endtask

  task automatic test_rounding();
    // d=(-3,0), w=0.5: y = -1.5 -> -1 unscaled, -0.75 -> -1 scaled; x=(3,0) -> 2 scaled
    drive(0, 0, 3, 0, 16384, 0, 1'b0, 1'b1);
    tick(); valid_i = 1'b0; tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 0, 3, 0, -1, 0);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL round_neg got=%h exp=%h", got, expv); end
    drive(0, 0, 3, 0, 16384, 0, 1'b1, 1'b1);
    tick(); valid_i = 1'b0; tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 0, 2, 0, -1, 0);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL round_neg_scaled got=%h exp=%h", got, expv); end
    // w = (-1,-1) full scale, d=(1,1): yr = 0, yi = -65536 -> -2
    drive(1, 1, 0, 0, -32768, -32768, 1'b0, 1'b1);
    tick(); valid_i = 1'b0; tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 0, 1, 1, 0, -2);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL tw_extreme got=%h exp=%h", got, expv); end
  endtask

  task automatic test_saturate();
    drive(32767, 0, 32767, 0, 0, 0, 1'b0, 1'b1);
    tick(); valid_i = 1'b0; tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 1, 32767, 0, 0, 0);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL saturate got=%h exp=%h", got, expv); end
  endtask

  task automatic test_sticky();
    drive(32767, 0, 32767, 0, 0, 0, 1'b0, 1'b1);
    tick(); valid_i = 1'b0; tick();
    ovf_clr = 1'b1;
    tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 1, 32767, 0, 0, 0);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL sticky_set_wins got=%h exp=%h", got, expv); end
    tick();
    ovf_clr = 1'b0;
    n_vec++;
    if (ovf_o !== 1'b0) begin n_err++; $display("FAIL sticky_clear got=%b exp=0", ovf_o); end
  endtask

  task automatic test_invalid_clamp();
    drive(32767, 0, 32767, 0, 0, 0, 1'b0, 1'b0);
    tick(); tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(0, 0, 32767, 0, 0, 0);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL invalid_clamp got=%h exp=%h", got, expv); end
  endtask

  task automatic test_neg_saturate();
    // d=-65535, w~+1: yr clamps low; s=-1 fits
    drive(-32768, 0, 32767, 0, 32767, 0, 1'b0, 1'b1);
    tick(); valid_i = 1'b0; tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 1, -1, 0, -32768, 0);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL neg_saturate got=%h exp=%h", got, expv); end
    ovf_clr = 1'b1; ce = 1'b0;
    tick();
    ovf_clr = 1'b0; ce = 1'b1;
    n_vec++;
    if (ovf_o !== 1'b0) begin n_err++; $display("FAIL clear_while_stalled got=%b exp=0", ovf_o); end
  endtask

  task automatic test_back_to_back();
    drive(1000, 200, 600, -100, 16384, 0, 1'b0, 1'b1);
    tick();
    drive(1000, 200, 600, -100, 16384, 0, 1'b1, 1'b1);
    tick(); valid_i = 1'b0; tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 0, 1600, 100, 200, 150);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", got, expv); end
    tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 0, 800, 50, 100, 75);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", got, expv); end
  endtask

  task automatic test_stall();
    drive(1000, 200, 600, -100, 16384, 0, 1'b0, 1'b1);
    tick();
    valid_i = 1'b0; ce = 1'b0;
    tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(0, 0, 800, 50, 100, 75);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL stall_hold got=%h exp=%h", got, expv); end
    ce = 1'b1;
    tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(0, 0, 800, 50, 100, 75);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL stall_not_early got=%h exp=%h", got, expv); end
    tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 0, 1600, 100, 200, 150);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL stall_result got=%h exp=%h", got, expv); end
  endtask

  task automatic test_reset_inflight();
    logic stale;
    drive(32767, 0, 32767, 0, 0, 0, 1'b0, 1'b1);
    tick();
    drive(1000, 200, 600, -100, 16384, 0, 1'b0, 1'b1);
    tick();
    drive(1000, 200, 600, -100, 16384, 0, 1'b1, 1'b1);
    tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 1, 32767, 0, 0, 0);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL pre_reset got=%h exp=%h", got, expv); end
    #1 RST = 1'b0;
    #1;
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL async_reset got=%h exp=%h", got, expv); end
    valid_i = 1'b0;
    tick();
    RST = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      stale = stale | valid_o;
    end
    n_vec++;
    if (stale !== 1'b0) begin n_err++; $display("FAIL stale_valid got=%b exp=0", stale); end
    drive(1000, 200, 600, -100, 16384, 0, 1'b0, 1'b1);
    tick(); valid_i = 1'b0; tick(); tick();
    got = {valid_o, ovf_o, xr, xi, yr, yi}; expv = pack(1, 0, 1600, 100, 200, 150);
    n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL post_reset got=%h exp=%h", got, expv); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scale();
    test_rounding();
    test_saturate();
    test_sticky();
    test_invalid_clamp();
    test_neg_saturate();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
